// File: rtl/msk_tof_sched_pkg.sv
// Shared constants for the Toffoli-gadget scheduler: response FIFO depth,
// pointer/credit widths and the HPC2 randomness width helper.
package msk_tof_sched_pkg;

   localparam int DEPTH  = 4;
   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CRED_W = $clog2(DEPTH + 1);

   // Fresh random bits consumed by one HPC2 multiplication with d shares.
   function automatic int hpc2rnd(input int d);
      return d * (d - 1) / 2;
   endfunction

endpackage

// File: rtl/MSKand_hpc2o_tof.sv
// HPC2 masked Toffoli gadget: out = ina*inb ^ inc, two register stages.
// inb and rnd arrive one cycle before ina, inc and the delayed inb_prev.
module MSKand_hpc2o_tof #(
   parameter int d = 2,
   localparam int RND_W = d * (d - 1) / 2
) (
   input  logic             clk,
   input  logic [d-1:0]     ina,
   input  logic [d-1:0]     inb,
   input  logic [d-1:0]     inb_prev,
   input  logic [d-1:0]     inc,
   input  logic [RND_W-1:0] rnd,
   output logic [d-1:0]     out
);

   logic [d-1:0] out_next;

   for (genvar i = 0; i < d; i++) begin : g_row
      logic [d-1:0] term;
      for (genvar j = 0; j < d; j++) begin : g_col
         if (i == j) begin : g_diag
            assign term[j] = ina[i] & inb_prev[i];
         end else begin : g_cross
            // r_ij == r_ji so the randomness cancels across output shares.
            localparam int LO = (i < j) ? i : j;
            localparam int HI = (i < j) ? j : i;
            localparam int K  = LO * (d - 1) - LO * (LO - 1) / 2 + (HI - LO - 1);
            logic s_q;
            logic r_q;
            always_ff @(posedge clk) begin
               s_q <= inb[j] ^ rnd[K];
               r_q <= rnd[K];
            end
            assign term[j] = (~ina[i] & r_q) ^ (ina[i] & s_q);
         end
      end
      assign out_next[i] = (^term) ^ inc[i];
   end

   always_ff @(posedge clk) begin
      out <= out_next;
   end

endmodule

// File: rtl/msk_rr_arb.sv
// Round-robin arbiter: one-hot grant searching from last+1; the pointer
// moves to the granted requester only when advance is high.
module msk_rr_arb
   import msk_tof_sched_pkg::*;
#(
   parameter int NREQ = 4,
   localparam int IDW = $clog2(NREQ)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req,
   input  logic            advance,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  grant_id,
   output logic [IDW-1:0]  last
);

   logic [IDW-1:0] cand [NREQ];
   logic [NREQ-1:0] hit;

   for (genvar k = 0; k < NREQ; k++) begin : g_cand
      assign cand[k] = IDW'((int'(last) + k + 1) % NREQ);
      assign hit[k]  = req[cand[k]];
   end

   always_comb begin
      grant    = '0;
      grant_id = '0;
      // Walk candidates from highest offset down so the nearest one wins.
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (hit[k]) begin
            grant_id = cand[k];
         end
      end
      if (|hit) begin
         grant[grant_id] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last <= IDW'(NREQ - 1);
      end else if (advance) begin
         last <= grant_id;
      end
   end

endmodule

// File: rtl/msk_tof_sched.sv
// Credit-limited scheduler sharing one HPC2 Toffoli gadget among NREQ
// requesters; results return tagged with the requester id through a FIFO.
module msk_tof_sched
   import msk_tof_sched_pkg::*;
#(
   parameter int d    = 2,
   parameter int NREQ = 4,
   localparam int IDW   = $clog2(NREQ),
   localparam int RND_W = hpc2rnd(d)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*d-1:0] req_a,
   input  logic [NREQ*d-1:0] req_b,
   input  logic [NREQ*d-1:0] req_c,
   input  logic              rnd_valid,
   input  logic [RND_W-1:0]  rnd_in,
   output logic              rnd_ready,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IDW-1:0]    rsp_id,
   output logic [d-1:0]      rsp_out
);

   localparam int ENT_W = IDW + d;

   // Handshake: a requester transfers when req_valid[i] & req_ready[i];
   // req_ready is one-hot and only raised with randomness and a credit in
   // hand, so rnd_ready equals "an accept happens"; rsp pops on
   // rsp_valid & rsp_ready.
   logic [NREQ-1:0] grant;
   logic [IDW-1:0]  grant_id;
   logic [IDW-1:0]  arb_last;
   logic            accept;
   logic            push;
   logic            pop;
   logic [CRED_W-1:0] credits;

   assign accept    = rnd_valid & (credits != '0) & (|req_valid);
   assign req_ready = {NREQ{accept}} & grant;
   assign rnd_ready = accept;

   msk_rr_arb #(.NREQ(NREQ)) u_arb (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req_valid),
      .advance  (accept),
      .grant    (grant),
      .grant_id (grant_id),
      .last     (arb_last)
   );

   logic [d-1:0] a_arr [NREQ];
   logic [d-1:0] b_arr [NREQ];
   logic [d-1:0] c_arr [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_slice
      assign a_arr[i] = req_a[i*d +: d];
      assign b_arr[i] = req_b[i*d +: d];
      assign c_arr[i] = req_c[i*d +: d];
   end

   // Stage registers named by the gadget phase they feed: s1 early, s2 late,
   // s3 aligned with the gadget output.
   logic             v1, v2, v3;
   logic [d-1:0]     s1_a, s1_b, s1_c, s2_a, s2_b, s2_c;
   logic [RND_W-1:0] s1_rnd;
   logic [IDW-1:0]   s1_id, s2_id, s3_id;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1 <= 1'b0;  v2 <= 1'b0;  v3 <= 1'b0;
         s1_a <= '0;  s1_b <= '0;  s1_c <= '0;  s1_rnd <= '0;  s1_id <= '0;
         s2_a <= '0;  s2_b <= '0;  s2_c <= '0;  s2_id <= '0;
         s3_id <= '0;
      end else begin
         v1 <= accept;
         if (accept) begin
            s1_a   <= a_arr[grant_id];
            s1_b   <= b_arr[grant_id];
            s1_c   <= c_arr[grant_id];
            s1_rnd <= rnd_in;
            s1_id  <= grant_id;
         end
         v2    <= v1;
         s2_a  <= s1_a;
         s2_b  <= s1_b;
         s2_c  <= s1_c;
         s2_id <= s1_id;
         v3    <= v2;
         s3_id <= s2_id;
      end
   end

   logic [d-1:0]     g_ina, g_inb, g_inb_prev, g_inc, g_out;
   logic [RND_W-1:0] g_rnd;

   // Idle phases feed zeros so no stale share reaches the gadget.
   assign g_inb      = {d{v1}} & s1_a;
   assign g_rnd      = {RND_W{v1}} & s1_rnd;
   assign g_inb_prev = {d{v2}} & s2_a;
   assign g_ina      = {d{v2}} & s2_b;
   assign g_inc      = {d{v2}} & s2_c;

   MSKand_hpc2o_tof #(.d(d)) u_tof (
      .clk      (clk),
      .ina      (g_ina),
      .inb      (g_inb),
      .inb_prev (g_inb_prev),
      .inc      (g_inc),
      .rnd      (g_rnd),
      .out      (g_out)
   );

   logic [ENT_W-1:0]  fifo_mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CRED_W-1:0] fifo_cnt;
   logic [ENT_W-1:0]  head;

   assign push      = v3;
   assign rsp_valid = (fifo_cnt != '0);
   assign pop       = rsp_valid & rsp_ready;
   assign head      = fifo_mem[rd_ptr];
   assign rsp_id    = head[ENT_W-1:d];
   assign rsp_out   = head[d-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo_mem <= '{default: '0};
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) begin
            fifo_mem[wr_ptr] <= {s3_id, g_out};
            wr_ptr           <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + CRED_W'(1);
            2'b01:   fifo_cnt <= fifo_cnt - CRED_W'(1);
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   // Credits cover in-flight plus stored results, so a push never overflows.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         credits <= CRED_W'(DEPTH);
      end else begin
         case ({accept, pop})
            2'b10:   credits <= credits - CRED_W'(1);
            2'b01:   credits <= credits + CRED_W'(1);
            default: credits <= credits;
         endcase
      end
   end

endmodule
